// File: rtl/game_pkg.sv
// Shared definitions for the quiz game controller and its peripheral blocks.
// State codes appear directly on the STATE port, so they are fixed here.
package game_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0000,
    ST_LOAD     = 4'b0010,
    ST_QUESTION = 4'b0011,
    ST_INPUT    = 4'b0100,
    ST_JUDGE    = 4'b0101,
    ST_DRAW     = 4'b0110,
    ST_GOOD     = 4'b1000,
    ST_OUCH     = 4'b1001,
    ST_WIN      = 4'b1010,
    ST_LOSE     = 4'b1011
  } state_e;

  // Game counters hold at full scale instead of wrapping.
  function automatic logic [3:0] sat_inc(logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/game_ctrl_timer.sv
// Shared phase down-counter: loaded on phase entry, counts to zero and holds.
// done is high while the count is zero.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/game_ctrl.sv
// Quiz game sequencer: question fetch, timed answer window, judging,
// score/miss/round bookkeeping and timed result display.
module game_ctrl
  import game_pkg::*;
#(
  parameter int QUE_CYC   = 50_000_000,
  parameter int IN_CYC    = 500_000_000,
  parameter int RES_CYC   = 100_000_000,
  parameter int WIN_PTS   = 3,
  parameter int LOSE_MISS = 3,
  parameter int ROUNDS    = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       QUE_OK,
  input  logic       DEC,
  input  logic       JUDGE_VALID,
  input  logic       JUDGE_OK,
  output logic [3:0] STATE,
  output logic       QUE_REQ,
  output logic [3:0] SCORE,
  output logic [3:0] MISS,
  output logic [3:0] ROUND
);

  localparam int MAX_QI  = (QUE_CYC > IN_CYC) ? QUE_CYC : IN_CYC;
  localparam int MAX_CYC = (MAX_QI > RES_CYC) ? MAX_QI : RES_CYC;
  localparam int TW_RAW  = $clog2(MAX_CYC);
  localparam int TW      = (TW_RAW < 1) ? 1 : TW_RAW;

  // Timer counts N-1..0 so the phase lasts exactly N cycles.
  localparam logic [TW-1:0] QUE_LD = TW'(QUE_CYC - 1);
  localparam logic [TW-1:0] IN_LD  = TW'(IN_CYC - 1);
  localparam logic [TW-1:0] RES_LD = TW'(RES_CYC - 1);

  state_e          state_q, state_d;
  state_e          ok_st, bad_st;
  logic            que_req_q, que_req_d;
  logic [3:0]      score_q, score_d;
  logic [3:0]      miss_q, miss_d;
  logic [3:0]      round_q, round_d;
  logic [3:0]      score_inc, miss_inc;
  logic            tmr_load, tmr_done;
  logic [TW-1:0]   tmr_val;

  phase_timer #(.W(TW)) u_timer (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign score_inc = sat_inc(score_q);
  assign miss_inc  = sat_inc(miss_q);

  always_comb begin
    ok_st  = ST_GOOD;
    bad_st = ST_OUCH;
    if (score_inc == 4'(WIN_PTS)) begin
      ok_st = ST_WIN;
    end else if (round_q == 4'(ROUNDS)) begin
      ok_st = ST_DRAW;
    end
    if (miss_inc == 4'(LOSE_MISS)) begin
      bad_st = ST_LOSE;
    end else if (round_q == 4'(ROUNDS)) begin
      bad_st = ST_DRAW;
    end
  end

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    miss_d   = miss_q;
    round_d  = round_q;
    tmr_load = 1'b0;
    tmr_val  = RES_LD;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          score_d = '0;
          miss_d  = '0;
          round_d = 4'd1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (QUE_OK) begin
          state_d  = ST_QUESTION;
          tmr_load = 1'b1;
          tmr_val  = QUE_LD;
        end
      end
      ST_QUESTION: begin
        if (tmr_done) begin
          state_d  = ST_INPUT;
          tmr_load = 1'b1;
          tmr_val  = IN_LD;
        end
      end
      ST_INPUT: begin
        if (DEC) begin
          state_d = ST_JUDGE;
        end else if (tmr_done) begin
          miss_d   = miss_inc;
          state_d  = bad_st;
          tmr_load = 1'b1;
        end
      end
      ST_JUDGE: begin
        if (JUDGE_VALID) begin
          tmr_load = 1'b1;
          if (JUDGE_OK) begin
            score_d = score_inc;
            state_d = ok_st;
          end else begin
            miss_d  = miss_inc;
            state_d = bad_st;
          end
        end
      end
      ST_GOOD, ST_OUCH: begin
        if (tmr_done) begin
          round_d = sat_inc(round_q);
          state_d = ST_LOAD;
        end
      end
      ST_WIN, ST_LOSE, ST_DRAW: begin
        if (tmr_done) begin
          round_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    que_req_d = (state_d == ST_LOAD) && (state_q != ST_LOAD);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      que_req_q <= 1'b0;
      score_q   <= '0;
      miss_q    <= '0;
      round_q   <= '0;
    end else begin
      state_q   <= state_d;
      que_req_q <= que_req_d;
      score_q   <= score_d;
      miss_q    <= miss_d;
      round_q   <= round_d;
    end
  end

  assign STATE   = state_q;
  assign QUE_REQ = que_req_q;
  assign SCORE   = score_q;
  assign MISS    = miss_q;
  assign ROUND   = round_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: two parameter sets share stimulus and are checked
// every cycle against an event-level game model plus literal scenarios.
module tb_game_ctrl;

  localparam int QC = 3;
  localparam int IC = 5;
  localparam int RC = 2;
  localparam int NR = 3;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 2;
  localparam int S_QUE  = 3;
  localparam int S_INP  = 4;
  localparam int S_JDG  = 5;
  localparam int S_DRAW = 6;
  localparam int S_GOOD = 8;
  localparam int S_OUCH = 9;
  localparam int S_WIN  = 10;
  localparam int S_LOSE = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic qok = 1'b0;
  logic dec = 1'b0;
  logic jv = 1'b0;
  logic jok = 1'b0;

  logic [3:0] st_a, sc_a, ms_a, rd_a;
  logic [3:0] st_b, sc_b, ms_b, rd_b;
  logic       qr_a, qr_b;

  int checks = 0;
  int errors = 0;
  int qreq_cnt = 0;
  logic [3:0] seq[$];

  always #5 clk = ~clk;

  game_ctrl #(
    .QUE_CYC(QC), .IN_CYC(IC), .RES_CYC(RC),
    .WIN_PTS(2), .LOSE_MISS(2), .ROUNDS(NR)
  ) dut_a (
    .CLK(clk), .RST(rst_n), .START(start), .QUE_OK(qok), .DEC(dec),
    .JUDGE_VALID(jv), .JUDGE_OK(jok), .STATE(st_a), .QUE_REQ(qr_a),
    .SCORE(sc_a), .MISS(ms_a), .ROUND(rd_a)
  );

  game_ctrl #(
    .QUE_CYC(QC), .IN_CYC(IC), .RES_CYC(RC),
    .WIN_PTS(4), .LOSE_MISS(4), .ROUNDS(NR)
  ) dut_b (
    .CLK(clk), .RST(rst_n), .START(start), .QUE_OK(qok), .DEC(dec),
    .JUDGE_VALID(jv), .JUDGE_OK(jok), .STATE(st_b), .QUE_REQ(qr_b),
    .SCORE(sc_b), .MISS(ms_b), .ROUND(rd_b)
  );

  // Game model: phase plus cycles spent in it, counters as plain ints.
  typedef struct {
    int st;
    int age;
    int score;
    int miss;
    int round;
    int qreq;
  } mdl_t;

  mdl_t m[2];

  function automatic mdl_t m_reset();
    mdl_t r;
    r.st = S_IDLE; r.age = 0; r.score = 0;
    r.miss = 0; r.round = 0; r.qreq = 0;
    return r;
  endfunction

  function automatic int inc(int v);
    return (v < 15) ? v + 1 : 15;
  endfunction

  function automatic mdl_t enter(mdl_t n, int s);
    n.st = s;
    n.age = 0;
    n.qreq = (s == S_LOAD) ? 1 : 0;
    return n;
  endfunction

  function automatic mdl_t step(mdl_t c, int wp, int lm,
                                bit s, bit q, bit d, bit v, bit o);
    mdl_t n;
    n = c;
    n.age = c.age + 1;
    n.qreq = 0;
    case (c.st)
      S_IDLE: if (s) begin
        n.score = 0; n.miss = 0; n.round = 1;
        n = enter(n, S_LOAD);
      end
      S_LOAD: if (q) n = enter(n, S_QUE);
      S_QUE: if (n.age == QC) n = enter(n, S_INP);
      S_INP: begin
        if (d) n = enter(n, S_JDG);
        else if (n.age == IC) begin
          n.miss = inc(c.miss);
          n = enter(n, (n.miss == lm) ? S_LOSE :
                       (c.round == NR) ? S_DRAW : S_OUCH);
        end
      end
      S_JDG: if (v) begin
        if (o) begin
          n.score = inc(c.score);
          n = enter(n, (n.score == wp) ? S_WIN :
                       (c.round == NR) ? S_DRAW : S_GOOD);
        end else begin
          n.miss = inc(c.miss);
          n = enter(n, (n.miss == lm) ? S_LOSE :
                       (c.round == NR) ? S_DRAW : S_OUCH);
        end
      end
      S_GOOD, S_OUCH: if (n.age == RC) begin
        n.round = inc(c.round);
        n = enter(n, S_LOAD);
      end
      default: if (n.age == RC) begin
        n.round = 0;
        n = enter(n, S_IDLE);
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= m_reset();
      m[1] <= m_reset();
    end else begin
      m[0] <= step(m[0], 2, 2, start, qok, dec, jv, jok);
      m[1] <= step(m[1], 4, 4, start, qok, dec, jv, jok);
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(string tag, int s, int q, int sc, int ms, int rd, mdl_t e);
    chk({tag, ".state"}, s, e.st);
    chk({tag, ".que_req"}, q, e.qreq);
    chk({tag, ".score"}, sc, e.score);
    chk({tag, ".miss"}, ms, e.miss);
    chk({tag, ".round"}, rd, e.round);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp("a", st_a, qr_a, sc_a, ms_a, rd_a, m[0]);
      cmp("b", st_b, qr_b, sc_b, ms_b, rd_b, m[1]);
    end
  end

  task automatic tick(bit s, bit q, bit d, bit v, bit o);
    @(negedge clk);
    seq.push_back(st_a);
    if (qr_a) qreq_cnt++;
    start = s; qok = q; dec = d; jv = v; jok = o;
  endtask

  task automatic idle(int n);
    repeat (n) tick(0, 0, 0, 0, 0);
  endtask

  task automatic to_input();
    tick(0, 1, 0, 0, 0);
    idle(QC);
  endtask

  task automatic round_ans(bit ok);
    to_input();
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, ok);
  endtask

  task automatic round_to();
    to_input();
    idle(IC);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 0; qok = 0; dec = 0; jv = 0; jok = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int count_of(int code);
    int n = 0;
    foreach (seq[k]) if (int'(seq[k]) == code) n++;
    return n;
  endfunction

  int exp_win[18] = '{0, 2, 3, 3, 3, 4, 5, 8, 8, 2, 3, 3, 3, 4, 5, 10, 10, 0};

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.state", st_a, S_IDLE);
    chk("reset.round", rd_a, 0);
    rst_n = 1'b1;
    idle(2);

    // win path
    seq.delete(); qreq_cnt = 0;
    tick(1, 0, 0, 0, 0);
    round_ans(1); idle(RC);
    round_ans(1); idle(RC);
    idle(1);
    chk("win.seq_len", seq.size(), 18);
    for (int k = 0; k < 18 && k < seq.size(); k++)
      chk($sformatf("win.seq[%0d]", k), seq[k], exp_win[k]);
    chk("win.que_req_pulses", qreq_cnt, 2);
    chk("win.score", sc_a, 2);
    chk("win.round", rd_a, 0);

    // lose path by two timeouts
    do_reset();
    seq.delete();
    tick(1, 0, 0, 0, 0);
    round_to(); idle(1);
    chk("lose.ouch", st_a, S_OUCH);
    chk("lose.miss1", ms_a, 1);
    idle(1);
    round_to(); idle(1);
    chk("lose.lose", st_a, S_LOSE);
    chk("lose.miss2", ms_a, 2);
    idle(RC);
    chk("lose.input_cycles", count_of(S_INP), 2 * IC);
    chk("lose.judge_cycles", count_of(S_JDG), 0);

    // ok, wrong, ok: WIN on a, DRAW on b
    do_reset();
    tick(1, 0, 0, 0, 0);
    round_ans(1); idle(RC);
    round_ans(0); idle(RC);
    round_ans(1); idle(1);
    chk("draw.a_state", st_a, S_WIN);
    chk("draw.b_state", st_b, S_DRAW);
    chk("draw.b_score", sc_b, 2);
    chk("draw.b_miss", ms_b, 1);
    chk("draw.b_round", rd_b, 3);
    idle(RC + 1);

    // DEC on the last INPUT cycle, then START ignored in JUDGE
    do_reset();
    tick(1, 0, 0, 0, 0);
    to_input(); idle(IC - 1);
    tick(0, 0, 1, 0, 0);
    idle(1);
    chk("dec_expiry.state", st_a, S_JDG);
    chk("dec_expiry.miss", ms_a, 0);
    tick(1, 1, 1, 0, 0);
    idle(1);
    chk("judge_start.state", st_a, S_JDG);
    chk("judge_start.que_req", qr_a, 0);
    tick(0, 0, 0, 1, 1);
    idle(RC);
    to_input();
    // we are now three QUESTION cycles deep; reset inside round 2 instead
    do_reset();
    tick(1, 0, 0, 0, 0);
    round_ans(1); idle(RC);
    tick(0, 1, 0, 0, 0);
    idle(1);
    chk("rst_pre.state", st_a, S_QUE);
    chk("rst_pre.round", rd_a, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async.state", st_a, S_IDLE);
    chk("rst_async.score", sc_a, 0);
    chk("rst_async.round", rd_a, 0);
    chk("rst_async.que_req", qr_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    qreq_cnt = 0;
    idle(4);
    chk("rst_after.state", st_a, S_IDLE);
    chk("rst_after.que_req", qreq_cnt, 0);

    // randomized play
    do_reset();
    repeat (3000) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- QUE_CYC, 50_000_000: cycles the QUESTION state is held.
- IN_CYC, 500_000_000: answer window in cycles.
- RES_CYC, 100_000_000: cycles each result state (GOOD/OUCH/DRAW/WIN/LOSE) is held.
- WIN_PTS, 3: correct answers that give WIN.
- LOSE_MISS, 3: misses that give LOSE.
- ROUNDS, 5: rounds per game.
REQ-002 Ports, one per line: name, direction, width, meaning.
- CLK, in, 1: single clock; all logic on its rising edge.
- RST, in, 1: asynchronous, active-low reset.
- START, in, 1: single-cycle pulse that starts a game.
- QUE_OK, in, 1: the question is stored in the input block.
- DEC, in, 1: single-cycle pulse; the player commits an answer.
- JUDGE_VALID, in, 1: the judge result is valid this cycle.
- JUDGE_OK, in, 1: the answer is correct; sampled only when JUDGE_VALID=1.
- STATE, out, 4: current state code, registered.
- QUE_REQ, out, 1: single-cycle pulse that requests the next question from the DB.
- SCORE, out, 4: correct answers in the current game.
- MISS, out, 4: wrong answers plus timeouts in the current game.
- ROUND, out, 4: current round, 1..ROUNDS; 0 in IDLE.

Function
REQ-003 STATE encoding SHALL be:
- IDLE=0000, LOAD=0010, QUESTION=0011, INPUT=0100, JUDGE=0101
- DRAW=0110, GOOD=1000, OUCH=1001, WIN=1010, LOSE=1011
- No other code SHALL ever appear on STATE.
REQ-004 IDLE: START=1 SHALL clear SCORE and MISS, set ROUND=1 and go to LOAD next cycle; START SHALL be ignored in every other state.
REQ-005 Entry to LOAD SHALL assert QUE_REQ for exactly the first cycle in LOAD; LOAD SHALL hold until QUE_OK=1, then go to QUESTION.
REQ-006 QUESTION SHALL last exactly QUE_CYC cycles, then go to INPUT.
REQ-007 INPUT SHALL leave on DEC=1 (to JUDGE) or after IN_CYC cycles without DEC (timeout, counted as a miss).
- If DEC arrives in the same cycle the timer expires, DEC SHALL win.
REQ-008 JUDGE SHALL hold until JUDGE_VALID=1; DEC, START and QUE_OK SHALL be ignored there.
REQ-009 Correct result (JUDGE_VALID=1, JUDGE_OK=1):
- SCORE increments.
- Next state is WIN if the new SCORE == WIN_PTS.
- Otherwise DRAW if ROUND == ROUNDS.
- Otherwise GOOD.
REQ-010 Wrong result or timeout:
- MISS increments.
- Next state is LOSE if the new MISS == LOSE_MISS.
- Otherwise DRAW if ROUND == ROUNDS.
- Otherwise OUCH.
REQ-011 Each result state SHALL last exactly RES_CYC cycles.
- GOOD/OUCH then go to LOAD with ROUND+1.
- WIN/LOSE/DRAW then go to IDLE with ROUND=0; SCORE and MISS stay held until the next START.
REQ-012 A single down-counter, width clog2 of the largest cycle parameter, SHALL be shared by QUESTION, INPUT and the result states.
- It is loaded on state entry and decremented each cycle; the state exits when it reaches 0.
REQ-013 SCORE, MISS and ROUND SHALL change only on the transitions named in REQ-004, REQ-009, REQ-010 and REQ-011; they never wrap.
REQ-014 Latency:
- STATE changes one cycle after the qualifying input is sampled.
- QUE_REQ is registered and aligned with STATE=LOAD.

Reset
REQ-015 While RST=0 the block SHALL immediately (asynchronously) force: STATE=IDLE, QUE_REQ=0, SCORE=0, MISS=0, ROUND=0, timer=0.
REQ-016 Reset asserted mid-game SHALL abort the game; the block SHALL restart only on a START pulse after RST deasserts.

Structure
REQ-017 The state codes (REQ-003) SHALL live in shared package game_pkg, used by game_ctrl, the input block, the judge and the 7-segment display blocks.
REQ-018 The shared timer SHALL be sub-module phase_timer (load value, load strobe, done flag); the FSM and counters stay in game_ctrl.

Verification
REQ-019 The bench SHALL use QUE_CYC=3, IN_CYC=5, RES_CYC=2, WIN_PTS=2, LOSE_MISS=2, ROUNDS=3, and SHALL cover:
- Win path: START, QUE_OK, DEC, JUDGE_OK=1 twice -> sequence LOAD,QUESTION(3),INPUT,JUDGE,GOOD(2),LOAD...,WIN(2),IDLE; SCORE=2, QUE_REQ pulsed twice.
- Lose path: two INPUT timeouts, each after exactly 5 cycles -> OUCH, then LOSE; MISS=2; JUDGE never entered.
- Draw: correct, wrong, correct-but-round-3 with SCORE ending 1... use correct, wrong, wrong-blocked? Concrete case: round1 ok (SCORE=1), round2 wrong (MISS=1), round3 ok? -> WIN takes priority; round3 DEC-wrong at MISS=1 -> LOSE; bench variant with WIN_PTS=4, LOSE_MISS=4: ok, wrong, ok -> DRAW at ROUND=3.
- DEC in the same cycle the INPUT timer expires -> JUDGE, MISS unchanged.
- RST=0 during QUESTION of round 2 -> STATE=IDLE and counters 0 in the same cycle; START ignored in JUDGE; no QUE_REQ without LOAD.
